// File: rtl/ptw_arbiter.sv
// -----------------------------------------------------------------------------
// ptw_arbiter
//
// Shares a single Page Table Walker between NUM_REQ TLB requesters. One walk is
// in flight at a time; requesters are granted in round-robin order starting at
// rr_ptr. A watchdog synthesises an all-zero (faulting) PTE when the PTW does
// not answer within TIMEOUT cycles. The late PTW answer is then drained and
// discarded so it can never be mistaken for the next walk's response.
//
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready are both 1. A valid driven by this block stays high, with stable
// data, until it is accepted.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   req_valid_i       per-requester walk request valid          [NUM_REQ]
//   req_ready_o       per-requester request ready (comb)        [NUM_REQ]
//   req_vaddr_i       request vaddrs, requester i at [32i+:32]  [NUM_REQ*32]
//   resp_valid_o      per-requester response valid (one-hot)    [NUM_REQ]
//   resp_ready_i      per-requester response ready              [NUM_REQ]
//   resp_pte_o        returned PTE (shared bus)                 [32]
//   resp_timeout_o    response was synthesised by the watchdog
//   ptw_req_valid_o   PTW request valid
//   ptw_req_ready_i   PTW request ready
//   ptw_vaddr_o       PTW virtual address                       [32]
//   ptw_resp_valid_i  PTW response valid
//   ptw_resp_ready_o  PTW response ready
//   ptw_pte_i         PTE from the PTW                          [32]
//   busy_o            high whenever the FSM is not IDLE
//   grant_id_o        index of the current / last granted requester
//   timeout_err_o     sticky watchdog-expiry flag
//   dbg_state_o       current FSM state (IDLE=0 ISSUE=1 WAIT_RESP=2
//                     RETURN=3 DRAIN=4)
// -----------------------------------------------------------------------------
module ptw_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256,
  parameter int ID_BITS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*32-1:0]  req_vaddr_i,
  output logic [NUM_REQ-1:0]     resp_valid_o,
  input  logic [NUM_REQ-1:0]     resp_ready_i,
  output logic [31:0]            resp_pte_o,
  output logic                   resp_timeout_o,
  output logic                   ptw_req_valid_o,
  input  logic                   ptw_req_ready_i,
  output logic [31:0]            ptw_vaddr_o,
  input  logic                   ptw_resp_valid_i,
  output logic                   ptw_resp_ready_o,
  input  logic [31:0]            ptw_pte_i,
  output logic                   busy_o,
  output logic [ID_BITS-1:0]     grant_id_o,
  output logic                   timeout_err_o,
  output logic [2:0]             dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    RETURN    = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  // Timer is sized to hold TIMEOUT without wrapping; one bit when disabled.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t              state;
  logic [ID_BITS-1:0]  rr_ptr;
  logic [TW-1:0]       timer;

  // ---------------------------------------------------------------------------
  // Round-robin winner search. Scanning offsets from high to low lets the
  // smallest offset from rr_ptr overwrite the others, so no "found" chain is
  // needed inside the loop.
  // ---------------------------------------------------------------------------
  logic [ID_BITS-1:0] winner;
  logic [ID_BITS-1:0] idx;
  logic               found;

  always_comb begin
    winner = rr_ptr;
    idx    = '0;
    found  = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_BITS'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Ready is only offered to the winner, only in IDLE and never during reset.
  always_comb begin
    req_ready_o = '0;
    if (rst && (state == IDLE) && found) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  // One-hot of the granted requester, used to route the response.
  logic [NUM_REQ-1:0] grant_onehot;
  always_comb begin
    grant_onehot             = '0;
    grant_onehot[grant_id_o] = 1'b1;
  end

  logic [ID_BITS-1:0] rr_next;
  assign rr_next = (int'(grant_id_o) == NUM_REQ - 1) ? '0
                                                      : grant_id_o + ID_BITS'(1);

  // A late PTW answer taken while still in RETURN after a timeout means the
  // stale response is already gone, so DRAIN is not needed afterwards.
  logic late_drained_now;
  assign late_drained_now = resp_timeout_o && ptw_resp_ready_o && ptw_resp_valid_i;

  // ---------------------------------------------------------------------------
  // Main FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      rr_ptr           <= '0;
      timer            <= '0;
      grant_id_o       <= '0;
      ptw_vaddr_o      <= '0;
      ptw_req_valid_o  <= 1'b0;
      ptw_resp_ready_o <= 1'b0;
      resp_valid_o     <= '0;
      resp_pte_o       <= '0;
      resp_timeout_o   <= 1'b0;
      timeout_err_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            grant_id_o      <= winner;
            ptw_vaddr_o     <= req_vaddr_i[{winner, 5'b00000} +: 32];
            ptw_req_valid_o <= 1'b1;
            state           <= ISSUE;
          end
        end

        ISSUE: begin
          if (ptw_req_ready_i) begin
            ptw_req_valid_o  <= 1'b0;
            ptw_resp_ready_o <= 1'b1;
            timer            <= '0;
            state            <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          // A real response beats a watchdog expiry in the same cycle.
          if (ptw_resp_valid_i) begin
            resp_pte_o       <= ptw_pte_i;
            ptw_resp_ready_o <= 1'b0;
            resp_timeout_o   <= 1'b0;
            resp_valid_o     <= grant_onehot;
            state            <= RETURN;
          end else if (TIMEOUT != 0) begin
            if (timer == TIMER_LAST) begin
              // Keep ptw_resp_ready_o high so the late answer can be drained.
              resp_pte_o     <= '0;
              resp_timeout_o <= 1'b1;
              timeout_err_o  <= 1'b1;
              resp_valid_o   <= grant_onehot;
              state          <= RETURN;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end

        RETURN: begin
          if (late_drained_now) begin
            ptw_resp_ready_o <= 1'b0;
          end
          if (resp_ready_i[grant_id_o]) begin
            resp_valid_o   <= '0;
            resp_timeout_o <= 1'b0;
            rr_ptr         <= rr_next;
            if (resp_timeout_o && ptw_resp_ready_o && !ptw_resp_valid_i) begin
              state <= DRAIN;
            end else begin
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          // Discard the late PTE; a PTW that never answers holds us here.
          if (ptw_resp_valid_i) begin
            ptw_resp_ready_o <= 1'b0;
            state            <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

  // ---------------------------------------------------------------------------
  // Structural properties of the outputs.
  // ---------------------------------------------------------------------------
  property p_resp_onehot;
    @(posedge clk) disable iff (!rst) $onehot0(resp_valid_o);
  endproperty
  a_resp_onehot: assert property (p_resp_onehot);

  property p_ptw_req_hold;
    @(posedge clk) disable iff (!rst)
      (ptw_req_valid_o && !ptw_req_ready_i) |=> (ptw_req_valid_o && $stable(ptw_vaddr_o));
  endproperty
  a_ptw_req_hold: assert property (p_ptw_req_hold);

  property p_resp_hold;
    @(posedge clk) disable iff (!rst)
      ((|resp_valid_o) && !(|(resp_valid_o & resp_ready_i)))
        |=> ($stable(resp_valid_o) && $stable(resp_pte_o));
  endproperty
  a_resp_hold: assert property (p_resp_hold);

endmodule
